ov7670_sccb_ctrl: RTL

OV7670_SCCB_CTRL -- requirements
Module: ov7670_sccb_ctrl

---
 rtl/ov7670_sccb_ctrl.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/ov7670_sccb_ctrl.sv
// SCCB (I2C-like) write-only master that walks an external register ROM and
// programs an OV7670 camera.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | bus idle high, waiting for a start pulse
//   CHECK  | one cycle: sample the ROM word, finish or latch a new frame
//   START  | 2 quarters: SIOD falls while SIOC is high, then SIOC falls
//   SHIFT  | 27 bit slots x 4 quarters, MSB first, slots 9/18/27 released
//   STOP   | 3 quarters: SIOD rises while SIOC is high; token on the last tick
//   GAP    | 4 quarters of idle bus between writes
//   SETTLE | RST_WAIT cycles of idle bus after a COM7 soft-reset write
//   DONE   | end of table reached, parked until reset
module ov7670_sccb_ctrl #(
  parameter int         QTR_CNT  = 125,
  parameter int         RST_WAIT = 50000,
  parameter logic [7:0] DEV_ADDR = 8'h42
) (
  input  logic        ov7670_clk50,
  input  logic        reg_conf_rst_n,
  input  logic        start,
  input  logic [15:0] command,
  input  logic        reg_conf_finish,
  output logic        token,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        config_done
);

  localparam int TW = $clog2(QTR_CNT);
  localparam int WW = $clog2(RST_WAIT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_START, S_SHIFT, S_STOP, S_GAP, S_SETTLE, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic [1:0]      qtr_q, qtr_d;
  logic [4:0]      bit_q, bit_d;
  logic [26:0]     frame_q, frame_d;
  logic            is_reset_q, is_reset_d;
  logic [WW-1:0]   wait_q, wait_d;
  logic            qtick;
  logic            entering;
  logic            load_frame;

  assign qtick      = (tick_q == TW'(QTR_CNT - 1));
  assign entering   = (state_d != state_q);
  assign load_frame = (state_q == S_CHECK) && !reg_conf_finish;

  // State and datapath registers; reset parks the bus idle and drops any frame.
  always_ff @(posedge ov7670_clk50 or negedge reg_conf_rst_n) begin
    if (!reg_conf_rst_n) begin
      state_q    <= S_IDLE;
      tick_q     <= '0;
      qtr_q      <= '0;
      bit_q      <= '0;
      frame_q    <= '0;
      is_reset_q <= 1'b0;
      wait_q     <= '0;
    end else begin
      state_q    <= state_d;
      tick_q     <= tick_d;
      qtr_q      <= qtr_d;
      bit_q      <= bit_d;
      frame_q    <= frame_d;
      is_reset_q <= is_reset_d;
      wait_q     <= wait_d;
    end
  end

  // Next-state logic; every bus phase boundary waits for a quarter tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_CHECK;
      S_CHECK:  state_d = reg_conf_finish ? S_DONE : S_START;
      S_START:  if (qtick && qtr_q == 2'd1) state_d = S_SHIFT;
      S_SHIFT:  if (qtick && qtr_q == 2'd3 && bit_q == 5'd26) state_d = S_STOP;
      S_STOP:   if (qtick && qtr_q == 2'd2) state_d = is_reset_q ? S_SETTLE : S_GAP;
      S_GAP:    if (qtick && qtr_q == 2'd3) state_d = S_CHECK;
      S_SETTLE: if (wait_q == '0) state_d = S_CHECK;
      S_DONE:   state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Quarter timing, bit position, shift frame and settle timer.
  always_comb begin
    tick_d     = (entering || qtick) ? '0 : tick_q + TW'(1);
    qtr_d      = entering ? 2'd0 : (qtick ? qtr_q + 2'd1 : qtr_q);
    bit_d      = bit_q;
    frame_d    = frame_q;
    is_reset_d = is_reset_q;
    wait_d     = wait_q;
    if (entering)
      bit_d = '0;
    else if (state_q == S_SHIFT && qtick && qtr_q == 2'd3)
      bit_d = bit_q + 5'd1;
    if (load_frame) begin
      // Each byte is followed by a released slot for the slave's don't-care bit.
      frame_d    = {DEV_ADDR, 1'b0, command[15:8], 1'b0, command[7:0], 1'b0};
      is_reset_d = (command == 16'h1280);
    end else if (state_q == S_SHIFT && qtick && qtr_q == 2'd3) begin
      frame_d = {frame_q[25:0], 1'b0};
    end
    if (entering && state_d == S_SETTLE)
      wait_d = WW'(RST_WAIT - 1);
    else if (state_q == S_SETTLE && wait_q != '0)
      wait_d = wait_q - WW'(1);
  end

  // Bus and status outputs decoded from the registered state.
  always_comb begin
    sioc        = 1'b1;
    siod_out    = 1'b1;
    siod_oe     = 1'b1;
    token       = 1'b0;
    busy        = 1'b1;
    config_done = 1'b0;
    case (state_q)
      S_IDLE: busy = 1'b0;
      S_DONE: begin
        busy        = 1'b0;
        config_done = 1'b1;
      end
      S_START: begin
        siod_out = 1'b0;
        sioc     = (qtr_q == 2'd0);
      end
      S_SHIFT: begin
        sioc = qtr_q[1];
        if (bit_q == 5'd8 || bit_q == 5'd17 || bit_q == 5'd26) begin
          siod_oe  = 1'b0;
          siod_out = 1'b0;
        end else begin
          siod_out = frame_q[26];
        end
      end
      S_STOP: begin
        sioc     = (qtr_q != 2'd0);
        siod_out = (qtr_q == 2'd2);
        token    = qtick && (qtr_q == 2'd2);
      end
      default: ;
    endcase
  end

endmodule
